// File: rtl/sram_rw_arbiter.sv
// Purpose : front-end for a 128-set x 8-way x 20-bit two-port SRAM; zero-sweeps after reset, then arbitrates reads/writes.
// Latency : writes reach the SRAM ports in the accept cycle; read data is returned exactly 1 cycle after acceptance.
// Backpr. : both readys low during the sweep; no response back-pressure; same-set read stalls behind a write unless bypass is built.
//
// Build option: define SRAM_BYPASS_EN to accept a read that collides with a same-cycle write to the
// same set. The write value is then forwarded into the response. Without it, that read is held off a cycle.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   io_init_done        high once every set has been zeroed
//   io_rreq_*           read request handshake + set index
//   io_rresp_*          read response, valid for exactly one cycle, no hold
//   io_wreq_*           write request handshake + set, data, per-way mask
//   io_sram_r_*         SRAM read port (address out, data in one cycle later)
//   io_sram_w_*         SRAM write port (enable, address, data, per-way mask)

module sram_rw_arbiter #(
    parameter  int SETS      = 128,
    parameter  int ADDR_BITS = 7,
    parameter  int WAYS      = 8,
    parameter  int WAY_BITS  = 20,
    localparam int DATA_BITS = WAYS * WAY_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 io_init_done,
    input  logic                 io_rreq_valid,
    output logic                 io_rreq_ready,
    input  logic [ADDR_BITS-1:0] io_rreq_set,
    output logic                 io_rresp_valid,
    output logic [DATA_BITS-1:0] io_rresp_data,
    input  logic                 io_wreq_valid,
    output logic                 io_wreq_ready,
    input  logic [ADDR_BITS-1:0] io_wreq_set,
    input  logic [DATA_BITS-1:0] io_wreq_data,
    input  logic [WAYS-1:0]      io_wreq_mask,
    output logic [ADDR_BITS-1:0] io_sram_r_addr,
    input  logic [DATA_BITS-1:0] io_sram_r_data,
    output logic                 io_sram_w_en,
    output logic [ADDR_BITS-1:0] io_sram_w_addr,
    output logic [DATA_BITS-1:0] io_sram_w_data,
    output logic [WAYS-1:0]      io_sram_w_mask
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [0:0]           state_q;
    logic [ADDR_BITS-1:0] init_cnt_q;
    logic                 in_idle;
    logic                 sweep_last;
    logic                 set_match;
    logic                 rd_fire;
    logic                 wr_fire;
    logic                 rresp_vld_q;

    assign in_idle    = (state_q == ST_IDLE);
    assign sweep_last = (init_cnt_q == ADDR_BITS'(SETS - 1));
    assign set_match  = (io_rreq_set == io_wreq_set);

    // ------------------------------------------------------------------
    // Request handshakes
    // ------------------------------------------------------------------
    assign io_init_done  = in_idle;
    assign io_wreq_ready = in_idle;

`ifdef SRAM_BYPASS_EN
    // Colliding reads are absorbed by the forwarding path below.
    assign io_rreq_ready = in_idle;
`else
    // A same-set write in flight this cycle would make the SRAM read
    // undefined, so the read yields and retries next cycle.
    assign io_rreq_ready = in_idle && !(io_wreq_valid && set_match);
`endif

    assign rd_fire = io_rreq_valid && io_rreq_ready;
    assign wr_fire = io_wreq_valid && io_wreq_ready;

    // ------------------------------------------------------------------
    // SRAM port drive
    // ------------------------------------------------------------------
    // The read address follows the request set unconditionally; a read
    // that is not accepted simply produces data nobody consumes.
    assign io_sram_r_addr = io_rreq_set;

    always_comb begin
        io_sram_w_en   = 1'b0;
        io_sram_w_addr = io_wreq_set;
        io_sram_w_data = io_wreq_data;
        io_sram_w_mask = io_wreq_mask;
        if (!in_idle) begin
            // Zero sweep: one full-width write per cycle, set = counter.
            io_sram_w_en   = 1'b1;
            io_sram_w_addr = init_cnt_q;
            io_sram_w_data = '0;
            io_sram_w_mask = '1;
        end else begin
            io_sram_w_en   = wr_fire;
        end
    end

    // ------------------------------------------------------------------
    // Sweep sequencer. IDLE is terminal until the next reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (sweep_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read response: SRAM data lands the cycle after the address, so the
    // valid flag is just the accept pulse delayed by one.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rresp_vld_q <= 1'b0;
        end else begin
            rresp_vld_q <= rd_fire;
        end
    end

    assign io_rresp_valid = rresp_vld_q;

`ifdef SRAM_BYPASS_EN
    logic                 byp_vld_q;
    logic [WAYS-1:0]      byp_mask_q;
    logic [DATA_BITS-1:0] byp_data_q;

    // Capture the write that landed on the same set as the accepted read,
    // so the response reflects the post-write contents of that set.
    always_ff @(posedge clock) begin
        if (reset) begin
            byp_vld_q <= 1'b0;
        end else begin
            byp_vld_q <= rd_fire && wr_fire && set_match;
        end
    end

    // Payload registers only load on a collision and need no reset:
    // they are never observed unless byp_vld_q is set.
    always_ff @(posedge clock) begin
        if (rd_fire && wr_fire && set_match) begin
            byp_mask_q <= io_wreq_mask;
            byp_data_q <= io_wreq_data;
        end
    end

    // Written ways come from the captured write, untouched ways from the
    // SRAM, whose data for unwritten ways is unaffected by the collision.
    always_comb begin
        io_rresp_data = io_sram_r_data;
        for (int w = 0; w < WAYS; w++) begin
            if (byp_vld_q && byp_mask_q[w]) begin
                io_rresp_data[w*WAY_BITS +: WAY_BITS] = byp_data_q[w*WAY_BITS +: WAY_BITS];
            end
        end
    end
`else
    // Collisions never get accepted, so the raw SRAM data is always clean.
    assign io_rresp_data = io_sram_r_data;
`endif

endmodule
